// File: rtl/coffee_pkg.sv
// Shared coffee-machine definitions: coin values, change-dispenser FSM
// states, coin select and the active-low 7-segment glyphs ({g,f,e,d,c,b,a})
// used by the machine's displays.
package coffee_pkg;

  localparam int unsigned COIN_100_VALUE = 100;
  localparam int unsigned COIN_500_VALUE = 500;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    PULSE,
    GAP,
    DONE
  } change_state_t;

  typedef enum logic {
    COIN_100,
    COIN_500
  } coin_sel_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DIGIT_0 = 7'b1000000;
  localparam logic [6:0] SEG_DIGIT_1 = 7'b1111001;
  localparam logic [6:0] SEG_DIGIT_2 = 7'b0100100;
  localparam logic [6:0] SEG_DIGIT_3 = 7'b0110000;
  localparam logic [6:0] SEG_DIGIT_4 = 7'b0011001;
  localparam logic [6:0] SEG_DIGIT_5 = 7'b0010010;
  localparam logic [6:0] SEG_DIGIT_6 = 7'b0000010;
  localparam logic [6:0] SEG_DIGIT_7 = 7'b1111000;
  localparam logic [6:0] SEG_DIGIT_8 = 7'b0000000;
  localparam logic [6:0] SEG_DIGIT_9 = 7'b0010000;
  localparam logic [6:0] SEG_DASH    = 7'b0111111;

  // Digit for 0..9, dash for anything larger
  function automatic logic [6:0] seg_encode(input int unsigned value);
    logic [6:0] seg;
    case (value)
      0:       seg = SEG_DIGIT_0;
      1:       seg = SEG_DIGIT_1;
      2:       seg = SEG_DIGIT_2;
      3:       seg = SEG_DIGIT_3;
      4:       seg = SEG_DIGIT_4;
      5:       seg = SEG_DIGIT_5;
      6:       seg = SEG_DIGIT_6;
      7:       seg = SEG_DIGIT_7;
      8:       seg = SEG_DIGIT_8;
      9:       seg = SEG_DIGIT_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/coin_pulse_gen.sv
// Single-coin eject timer: on start, drives the selected coin output high
// for PULSE_CYCLES cycles, then holds both low for GAP_CYCLES cycles.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   start, coin_sel       - launch one coin (ignored while a coin is active)
//   coin_100_out/_500_out - registered eject pulses
//   pulse_last            - high during the final pulse cycle
//   finished              - high during the final gap cycle
module coin_pulse_gen
  import coffee_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      start,
  input  coin_sel_t coin_sel,
  output logic      coin_100_out,
  output logic      coin_500_out,
  output logic      pulse_last,
  output logic      finished
);

  localparam int unsigned MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             pulsing;
  logic             gapping;

  // Counter runs down to zero in each phase; the _last/finished flags are
  // raised one cycle early so the sequencing FSM can leave on time.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      pulsing      <= 1'b0;
      gapping      <= 1'b0;
      coin_100_out <= 1'b0;
      coin_500_out <= 1'b0;
      pulse_last   <= 1'b0;
      finished     <= 1'b0;
    end else if (pulsing) begin
      if (cnt == '0) begin
        pulsing      <= 1'b0;
        gapping      <= 1'b1;
        coin_100_out <= 1'b0;
        coin_500_out <= 1'b0;
        pulse_last   <= 1'b0;
        cnt          <= CNT_W'(GAP_CYCLES - 1);
        finished     <= (GAP_CYCLES == 1);
      end else begin
        cnt        <= cnt - CNT_W'(1);
        pulse_last <= (cnt == CNT_W'(1));
      end
    end else if (gapping) begin
      if (cnt == '0) begin
        gapping  <= 1'b0;
        finished <= 1'b0;
      end else begin
        cnt      <= cnt - CNT_W'(1);
        finished <= (cnt == CNT_W'(1));
      end
    end else if (start) begin
      pulsing      <= 1'b1;
      coin_100_out <= (coin_sel == COIN_100);
      coin_500_out <= (coin_sel == COIN_500);
      cnt          <= CNT_W'(PULSE_CYCLES - 1);
      pulse_last   <= (PULSE_CYCLES == 1);
      finished     <= 1'b0;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a requested amount greedily (500 coins first, then
// 100) from tracked coin stock as eject pulses, and reports any shortfall.
// Optional macro CHANGE_DISPLAY_EN adds change_display, an active-low
// 7-segment readout of the remaining change in hundreds.
// Ports:
//   clock, reset                   - rising-edge clock, sync active-high reset
//   req_valid/req_ready/req_amount - change request handshake
//   refill_100/refill_500          - one-cycle stock increment pulses
//   coin_100_out/coin_500_out      - eject pulses to the hoppers
//   busy, done, error, shortfall   - request status
//   stock_100, stock_500           - current coin stock
module change_dispenser
  import coffee_pkg::*;
#(
  parameter int unsigned AMOUNT_W       = 12,
  parameter int unsigned STOCK_W        = 6,
  parameter int unsigned PULSE_CYCLES   = 2,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned INIT_STOCK_100 = 20,
  parameter int unsigned INIT_STOCK_500 = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [AMOUNT_W-1:0] req_amount,
  input  logic                refill_100,
  input  logic                refill_500,
  output logic                coin_100_out,
  output logic                coin_500_out,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [AMOUNT_W-1:0] shortfall,
`ifdef CHANGE_DISPLAY_EN
  output logic [6:0]          change_display,
`endif
  output logic [STOCK_W-1:0]  stock_100,
  output logic [STOCK_W-1:0]  stock_500
);

  localparam logic [AMOUNT_W-1:0] AMT_100   = AMOUNT_W'(COIN_100_VALUE);
  localparam logic [AMOUNT_W-1:0] AMT_500   = AMOUNT_W'(COIN_500_VALUE);
  localparam logic [STOCK_W-1:0]  STOCK_MAX = {STOCK_W{1'b1}};

  change_state_t       state;
  logic [AMOUNT_W-1:0] remaining;
  logic                sel_500_c;
  logic                sel_100_c;
  logic                start_c;
  coin_sel_t           coin_sel_c;
  logic                pulse_last;
  logic                pulse_finished;

  // Greedy coin choice, only meaningful while in CHECK
  always_comb begin
    sel_500_c  = 1'b0;
    sel_100_c  = 1'b0;
    if (state == CHECK) begin
      if (remaining >= AMT_500 && stock_500 != '0) begin
        sel_500_c = 1'b1;
      end else if (remaining >= AMT_100 && stock_100 != '0) begin
        sel_100_c = 1'b1;
      end
    end
    start_c    = sel_500_c | sel_100_c;
    coin_sel_c = sel_500_c ? COIN_500 : COIN_100;
  end

  // Request sequencing FSM with registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      shortfall <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            remaining <= req_amount;
            error     <= 1'b0;
            shortfall <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (sel_500_c) begin
            remaining <= remaining - AMT_500;
            state     <= PULSE;
          end else if (sel_100_c) begin
            remaining <= remaining - AMT_100;
            state     <= PULSE;
          end else begin
            shortfall <= remaining;
            error     <= (remaining != '0);
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        PULSE: begin
          if (pulse_last) begin
            state <= GAP;
          end
        end
        GAP: begin
          if (pulse_finished) begin
            state <= CHECK;
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Stock counters: a refill coinciding with a payout cancels out;
  // refills at the maximum are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      stock_100 <= STOCK_W'(INIT_STOCK_100);
      stock_500 <= STOCK_W'(INIT_STOCK_500);
    end else begin
      if (sel_100_c && !refill_100) begin
        stock_100 <= stock_100 - STOCK_W'(1);
      end else if (refill_100 && !sel_100_c && stock_100 != STOCK_MAX) begin
        stock_100 <= stock_100 + STOCK_W'(1);
      end
      if (sel_500_c && !refill_500) begin
        stock_500 <= stock_500 - STOCK_W'(1);
      end else if (refill_500 && !sel_500_c && stock_500 != STOCK_MAX) begin
        stock_500 <= stock_500 + STOCK_W'(1);
      end
    end
  end

  coin_pulse_gen #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_pulse_gen (
    .clock        (clock),
    .reset        (reset),
    .start        (start_c),
    .coin_sel     (coin_sel_c),
    .coin_100_out (coin_100_out),
    .coin_500_out (coin_500_out),
    .pulse_last   (pulse_last),
    .finished     (pulse_finished)
  );

`ifdef CHANGE_DISPLAY_EN
  localparam int unsigned MAX_HUNDREDS = ((2 ** AMOUNT_W) - 1) / COIN_100_VALUE;

  logic [AMOUNT_W-1:0] hundreds;
  logic [AMOUNT_W-1:0] hundreds_load_c;
  logic [AMOUNT_W-1:0] hundreds_next_c;
  logic [AMOUNT_W-1:0] rest_c;

  // req_amount / 100 by bounded repeated subtraction
  always_comb begin
    rest_c          = req_amount;
    hundreds_load_c = '0;
    for (int i = 0; i < int'(MAX_HUNDREDS); i++) begin
      if (rest_c >= AMT_100) begin
        rest_c          = rest_c - AMT_100;
        hundreds_load_c = hundreds_load_c + AMOUNT_W'(1);
      end
    end
  end

  // Track hundreds: load on accept, step down with each coin launched
  always_comb begin
    hundreds_next_c = hundreds;
    if (state == IDLE && req_valid) begin
      hundreds_next_c = hundreds_load_c;
    end else if (sel_500_c) begin
      hundreds_next_c = hundreds - AMOUNT_W'(5);
    end else if (sel_100_c) begin
      hundreds_next_c = hundreds - AMOUNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hundreds       <= '0;
      change_display <= SEG_DIGIT_0;
    end else begin
      hundreds       <= hundreds_next_c;
      change_display <= seg_encode(32'(hundreds_next_c));
    end
  end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: a greedy payout model pushes the
// expected outcome of each request; a monitor pops and compares it on done.
module tb_change_dispenser;

  localparam int unsigned AMOUNT_W = 12;
  localparam int unsigned STOCK_W  = 6;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_valid2 = 1'b0;
  logic [AMOUNT_W-1:0] req_amount = '0;
  logic                refill_100 = 1'b0;
  logic                refill_500 = 1'b0;

  logic                req_ready, coin_100_out, coin_500_out, busy, done, error;
  logic [AMOUNT_W-1:0] shortfall;
  logic [STOCK_W-1:0]  stock_100, stock_500;

  logic                req_ready2, coin_100_out2, coin_500_out2, busy2, done2, error2;
  logic [AMOUNT_W-1:0] shortfall2;
  logic [STOCK_W-1:0]  stock2_100, stock2_500;

  always #5 clock = ~clock;

  change_dispenser u_dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_amount(req_amount), .refill_100(refill_100), .refill_500(refill_500),
    .coin_100_out(coin_100_out), .coin_500_out(coin_500_out), .busy(busy),
    .done(done), .error(error), .shortfall(shortfall),
    .stock_100(stock_100), .stock_500(stock_500)
  );

  change_dispenser #(.INIT_STOCK_100(1), .INIT_STOCK_500(0)) u_dut2 (
    .clock(clock), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_amount(req_amount), .refill_100(1'b0), .refill_500(1'b0),
    .coin_100_out(coin_100_out2), .coin_500_out(coin_500_out2), .busy(busy2),
    .done(done2), .error(error2), .shortfall(shortfall2),
    .stock_100(stock2_100), .stock_500(stock2_500)
  );

  typedef struct {
    int unsigned short_amt;
    int unsigned err;
    int unsigned n100;
    int unsigned n500;
    int unsigned s100;
    int unsigned s500;
  } exp_t;

  exp_t        sb[$];
  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned m100 = 20;
  int unsigned m500 = 10;
  int unsigned cyc100 = 0;
  int unsigned cyc500 = 0;
  bit          overlap = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard side: count eject cycles, compare each completed request
  always @(negedge clock) begin
    if (reset) begin
      cyc100  <= 0;
      cyc500  <= 0;
      overlap <= 1'b0;
    end else begin
      if (coin_100_out) cyc100 <= cyc100 + 1;
      if (coin_500_out) cyc500 <= cyc500 + 1;
      if (coin_100_out && coin_500_out) overlap <= 1'b1;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("shortfall", 32'(shortfall), e.short_amt);
          check("error", 32'(error), e.err);
          check("cycles_100", cyc100, e.n100 * 2);
          check("cycles_500", cyc500, e.n500 * 2);
          check("stock_100", 32'(stock_100), e.s100);
          check("stock_500", 32'(stock_500), e.s500);
          check("coin_overlap", 32'(overlap), 0);
        end
      end
      if (req_valid && req_ready) begin
        cyc100  <= 0;
        cyc500  <= 0;
        overlap <= 1'b0;
      end
    end
  end

  // Drive one request; returns one step after the accept edge (CHECK state).
  // With refill_on_dec, refill_500 coincides with the first 500 payout edge.
  task automatic request(input int unsigned amt, input bit refill_on_dec);
    exp_t        e;
    int unsigned rem;
    int unsigned s500_before;
    rem         = amt;
    e.n100      = 0;
    e.n500      = 0;
    s500_before = m500;
    while (rem >= 500 && m500 > 0) begin rem -= 500; m500--; e.n500++; end
    while (rem >= 100 && m100 > 0) begin rem -= 100; m100--; e.n100++; end
    if (refill_on_dec) m500++;
    e.short_amt = rem;
    e.err       = (rem != 0) ? 1 : 0;
    e.s100      = m100;
    e.s500      = m500;
    sb.push_back(e);
    req_valid  = 1'b1;
    req_amount = AMOUNT_W'(amt);
    tick();
    req_valid  = 1'b0;
    req_amount = AMOUNT_W'($urandom_range(0, 4095));
    if (refill_on_dec) begin
      refill_500 = 1'b1;
      tick();
      refill_500 = 1'b0;
      check("refill_dec_same_cycle", 32'(stock_500), s500_before);
    end
  endtask

  task automatic wait_done(input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      if (sb.size() == 0 && req_ready) break;
      tick();
    end
    check("request_completed", sb.size(), 0);
  endtask

  initial begin
    req_amount = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_shortfall", 32'(shortfall), 0);
    check("rst_coins", 32'({coin_100_out, coin_500_out}), 0);
    check("rst_stock_100", 32'(stock_100), 20);
    check("rst_stock_500", 32'(stock_500), 10);

    // 600: cycle-exact eject timing relative to the accept edge
    request(600, 0);
    for (int k = 1; k <= 13; k++) begin
      check($sformatf("t600_c500_k%0d", k), 32'(coin_500_out), (k == 2 || k == 3) ? 1 : 0);
      check($sformatf("t600_c100_k%0d", k), 32'(coin_100_out), (k == 7 || k == 8) ? 1 : 0);
      check($sformatf("t600_done_k%0d", k), 32'(done), (k == 12) ? 1 : 0);
      check($sformatf("t600_ready_k%0d", k), 32'(req_ready), (k == 13) ? 1 : 0);
      if (k < 13) tick();
    end
    wait_done(50);

    // 0: straight to DONE, no pulses
    request(0, 0);
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("t0_done_k%0d", k), 32'(done), (k == 2) ? 1 : 0);
      check($sformatf("t0_coins_k%0d", k), 32'({coin_100_out, coin_500_out}), 0);
      if (k < 3) tick();
    end
    wait_done(50);

    request(250, 0);
    wait_done(100);
    check("error_held", 32'(error), 1);
    check("shortfall_held", 32'(shortfall), 50);
    request(1050, 0);
    wait_done(100);

    // Reset during the second cycle of the first 500 pulse
    request(700, 0);
    tick();
    tick();
    check("abort_pulse_high", 32'(coin_500_out), 1);
    reset = 1'b1;
    sb.delete();
    tick();
    check("abort_coins", 32'({coin_100_out, coin_500_out}), 0);
    check("abort_ready", 32'(req_ready), 1);
    check("abort_done", 32'(done), 0);
    check("abort_stock_100", 32'(stock_100), 20);
    check("abort_stock_500", 32'(stock_500), 10);
    reset = 1'b0;
    m100  = 20;
    m500  = 10;
    begin
      int unsigned seen;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
        if (done) seen++;
        tick();
      end
      check("abort_no_done", seen, 0);
    end

    request(1700, 0);
    wait_done(200);
    request(500, 1);
    wait_done(100);

    // Saturate the 100 stock, then one more refill
    for (int k = 0; k < 50; k++) begin
      refill_100 = 1'b1;
      tick();
      if (m100 < 63) m100++;
    end
    refill_100 = 1'b0;
    check("sat_stock_100", 32'(stock_100), 63);
    refill_100 = 1'b1;
    tick();
    refill_100 = 1'b0;
    check("sat_stock_100_hold", 32'(stock_100), 63);
    request(2300, 0);
    wait_done(300);

    // Second instance: no 500s, one 100 -> pay 100, short 600
    begin
      int unsigned c100, c500;
      bit          seen;
      c100 = 0;
      c500 = 0;
      seen = 1'b0;
      req_amount = AMOUNT_W'(700);
      req_valid2 = 1'b1;
      tick();
      req_valid2 = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
        if (coin_100_out2) c100++;
        if (coin_500_out2) c500++;
        if (done2) begin
          seen = 1'b1;
          check("d2_shortfall", 32'(shortfall2), 600);
          check("d2_error", 32'(error2), 1);
        end
        tick();
      end
      check("d2_done_seen", 32'(seen), 1);
      check("d2_cycles_100", c100, 2);
      check("d2_cycles_500", c500, 0);
      check("d2_stock_100", 32'(stock2_100), 0);
      check("d2_stock_500", 32'(stock2_500), 0);
      tick();
      tick();
      check("d2_error_held", 32'(error2), 1);
      check("d2_ready", 32'(req_ready2), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Pays out change for the coffee machine by emitting physical coin-eject pulses.
- Direction is the opposite of the coin acceptor: the acceptor turns coin_100/coin_500 pulses into a credit; this block turns a change amount into coin_100_out/coin_500_out pulses.
- Pays greedily from tracked coin stock (500 first, then 100) and reports any unpayable shortfall.
- Sits between the coffee_machine control FSM (the requester) and the coin-hopper actuators.

Parameters:
- AMOUNT_W, 12, width of amounts in colones.
- STOCK_W, 6, width of each coin-stock counter; saturates at 2^STOCK_W-1.
- PULSE_CYCLES, 2, cycles each eject pulse stays high (>=1).
- GAP_CYCLES, 2, low cycles after each pulse (>=1).
- INIT_STOCK_100, 20, 100-coin stock loaded at reset.
- INIT_STOCK_500, 10, 500-coin stock loaded at reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  change request valid.
- req_ready  out  1  high only in IDLE.
- req_amount  in  AMOUNT_W  change to pay, in colones.
- refill_100  in  1  one-cycle pulse: +1 to the 100 stock.
- refill_500  in  1  one-cycle pulse: +1 to the 500 stock.
- coin_100_out  out  1  100-coin eject pulse.
- coin_500_out  out  1  500-coin eject pulse.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of a request.
- error  out  1  high with done when shortfall != 0; held until the next accept.
- shortfall  out  AMOUNT_W  amount not paid; held until the next accept.
- stock_100  out  STOCK_W  current 100-coin stock.
- stock_500  out  STOCK_W  current 500-coin stock.

Behaviour:
- Reset is synchronous and active-high.
  - State goes to IDLE; outputs: coin outputs 0, done 0, error 0, shortfall 0, busy 0, req_ready 1.
  - stock_100 = INIT_STOCK_100, stock_500 = INIT_STOCK_500.
  - Reset asserted mid-payout aborts at the next edge, with no done.
- Accept: a request is taken when req_valid && req_ready at a rising edge.
  - remaining <= req_amount; error and shortfall are cleared; state goes to CHECK.
  - req_amount is ignored when not accepted.
- FSM states: IDLE, CHECK, PULSE, GAP, DONE.
- CHECK (1 cycle):
  - If remaining >= 500 && stock_500 > 0: select 500, go to PULSE.
  - Else if remaining >= 100 && stock_100 > 0: select 100, go to PULSE.
  - Else: shortfall <= remaining, go to DONE.
- PULSE: the selected coin output is high for exactly PULSE_CYCLES cycles. The selected stock and remaining are decremented on the CHECK->PULSE edge. Then go to GAP.
- GAP: both coin outputs are low for GAP_CYCLES cycles, then go to CHECK.
- DONE (1 cycle): done=1 and error=(shortfall!=0); then go to IDLE.
- The two coin outputs are never high in the same cycle.
- Latency from the accept edge: CHECK is entered 1 cycle later. Each coin costs 1+PULSE_CYCLES+GAP_CYCLES cycles. DONE follows the final CHECK.
- Boundary cases:
  - Amount 0: CHECK then DONE, no pulses, error 0.
  - A residue below 100 (amount not a multiple of 100) ends up in shortfall with error=1.
  - A 500 coin is never split into 100s when stock_500=0: the block pays with 100s instead.
  - Refill at max stock is ignored (saturation).
  - Refill in the same cycle as a decrement of the same stock leaves that stock unchanged.
  - Refills are accepted in any state.

Optional Feature:
- Macro: CHANGE_DISPLAY_EN.
- Defined:
  - Adds output change_display [6:0], active-low, bit order {g,f,e,d,c,b,a}.
  - It shows the remaining change in hundreds, tracked by a separate counter loaded as req_amount/100 at accept. That value is computed by a repeated-subtract loop in IDLE→CHECK, not a divider, and is decremented by 5 or 1 with each coin.
  - Values 0-9 are shown as digits; >=10 is shown as a dash (g only).
  - Reset value: digit 0.
- Undefined: no port, no counter; all other behaviour identical.

Decomposition:
- Package coffee_pkg holds:
  - COIN_100_VALUE=100, COIN_500_VALUE=500.
  - Enum change_state_t {IDLE, CHECK, PULSE, GAP, DONE}.
  - The 7-seg digit/dash constants, shared with the coffee_machine displays.
- Sub-module coin_pulse_gen: a single-coin pulse/gap timer with start, coin_sel, coin_100_out, coin_500_out, and a finished strobe. The FSM sequences it once per coin.

Test Plan:
- Defaults, accept 600 at edge T -> coin_500_out high T+2..T+3; coin_100_out high T+7..T+8; done at T+12; req_ready at T+13; stock 19/9; shortfall 0; error 0.
- Accept 0 -> no pulses; done at T+2; error 0.
- Accept 250 -> two 100 pulses; done with shortfall 50, error 1; stock_100 18.
- INIT_STOCK_500=0, INIT_STOCK_100=1, accept 700 -> one 100 pulse; shortfall 600; error 1; stock_100 0.
- Assert reset during the second PULSE cycle -> coin outputs 0 and req_ready 1 next cycle; no done; stocks reinit to 20/10.
- stock_100 at 63 with refill_100 -> stays 63; refill_500 on the cycle the 500 stock decrements -> stock_500 unchanged.
